// File: rtl/ct_had_xtrig_matrix_pkg.sv
// Shared definitions for the cluster debug cross-trigger matrix:
// channel state encoding, default timing parameters and counter width.
package ct_had_xtrig_matrix_pkg;

   typedef enum logic [1:0] {
      XT_IDLE     = 2'b00,
      XT_ASSERT   = 2'b01,
      XT_WAIT_ACK = 2'b10
   } xt_state_e;

   localparam int unsigned XT_HOLD_CYC_DEF = 8;
   localparam int unsigned XT_TMO_CYC_DEF  = 255;
   localparam int unsigned XT_CNT_W        = 8;

endpackage

// File: rtl/ct_had_xtrig_matrix_if.sv
// Core-side bundle of the cross-trigger matrix: each core's outgoing
// enter/exit requests and debug status, and its incoming enter/exit requests.
interface ct_had_xtrig_matrix_if #(
   parameter int unsigned CORE_NUM = 4
);
   logic [CORE_NUM-1:0] core_enter_req_o;
   logic [CORE_NUM-1:0] core_exit_req_o;
   logic [CORE_NUM-1:0] core_dbgon;
   logic [CORE_NUM-1:0] core_enter_req_i;
   logic [CORE_NUM-1:0] core_exit_req_i;

   // cluster side: drives the outgoing requests and status
   modport master (
      output core_enter_req_o,
      output core_exit_req_o,
      output core_dbgon,
      input  core_enter_req_i,
      input  core_exit_req_i
   );

   // matrix side: consumes the outgoing requests, drives the incoming ones
   modport slave (
      input  core_enter_req_o,
      input  core_exit_req_o,
      input  core_dbgon,
      output core_enter_req_i,
      output core_exit_req_i
   );
endinterface

// File: rtl/ct_had_xtrig_chan.sv
// One cross-trigger channel: stretches a target request for a minimum hold
// time, then waits for the target's debug state to confirm or times out.
module ct_had_xtrig_chan
   import ct_had_xtrig_matrix_pkg::*;
#(
   parameter int unsigned HOLD_CYC = XT_HOLD_CYC_DEF,
   parameter int unsigned TMO_CYC  = XT_TMO_CYC_DEF
) (
   input  logic forever_coreclk,
   input  logic cpurst_b,
   input  logic trig,
   input  logic ack,
   input  logic tmo_clr,
   output logic req,
   output logic busy,
   output logic tmo
);

   localparam logic [XT_CNT_W-1:0] HOLD_LD  = XT_CNT_W'(HOLD_CYC - 1);
   localparam logic [XT_CNT_W-1:0] TMO_LIM  = XT_CNT_W'(TMO_CYC);
   localparam logic [XT_CNT_W-1:0] CNT_ZERO = {XT_CNT_W{1'b0}};
   localparam logic [XT_CNT_W-1:0] CNT_ONE  = {{(XT_CNT_W-1){1'b0}}, 1'b1};

   xt_state_e           state_r;
   xt_state_e           state_s;
   logic [XT_CNT_W-1:0] hold_cnt_r;
   logic [XT_CNT_W-1:0] hold_cnt_s;
   logic [XT_CNT_W-1:0] tmo_cnt_r;
   logic [XT_CNT_W-1:0] tmo_cnt_s;
   logic                ack_seen_r;
   logic                ack_seen_s;
   logic                tmo_set_s;
   logic                req_r;
   logic                busy_r;
   logic                tmo_r;

   // channel state register
   always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_r <= XT_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next state, counter updates and timeout detection; triggers outside IDLE are ignored
   always_comb begin
      state_s    = state_r;
      hold_cnt_s = hold_cnt_r;
      tmo_cnt_s  = tmo_cnt_r;
      ack_seen_s = ack_seen_r;
      tmo_set_s  = 1'b0;
      case (state_r)
         XT_IDLE: begin
            if (trig) begin
               state_s    = XT_ASSERT;
               hold_cnt_s = HOLD_LD;
               ack_seen_s = 1'b0;
            end else begin
               state_s    = XT_IDLE;
            end
         end
         XT_ASSERT: begin
            ack_seen_s = ack_seen_r | ack;
            if (hold_cnt_r == CNT_ZERO) begin
               tmo_cnt_s = CNT_ZERO;
               if (ack_seen_r | ack) begin
                  state_s = XT_IDLE;
               end else begin
                  state_s = XT_WAIT_ACK;
               end
            end else begin
               hold_cnt_s = hold_cnt_r - CNT_ONE;
            end
         end
         XT_WAIT_ACK: begin
            if (ack) begin
               state_s = XT_IDLE;
            end else if (tmo_cnt_r == TMO_LIM) begin
               state_s   = XT_IDLE;
               tmo_set_s = 1'b1;
            end else begin
               tmo_cnt_s = tmo_cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = XT_IDLE;
         end
      endcase
   end

   // counters, registered request/busy and sticky timeout flag (set beats clear)
   always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         hold_cnt_r <= CNT_ZERO;
         tmo_cnt_r  <= CNT_ZERO;
         ack_seen_r <= 1'b0;
         req_r      <= 1'b0;
         busy_r     <= 1'b0;
         tmo_r      <= 1'b0;
      end else begin
         hold_cnt_r <= hold_cnt_s;
         tmo_cnt_r  <= tmo_cnt_s;
         ack_seen_r <= ack_seen_s;
         req_r      <= (state_s != XT_IDLE);
         busy_r     <= (state_s != XT_IDLE);
         if (tmo_set_s) begin
            tmo_r <= 1'b1;
         end else if (tmo_clr) begin
            tmo_r <= 1'b0;
         end else begin
            tmo_r <= tmo_r;
         end
      end
   end

   assign req  = req_r;
   assign busy = busy_r;
   assign tmo  = tmo_r;

endmodule

// File: rtl/ct_had_xtrig_matrix.sv
// Cluster debug cross-trigger matrix: captures each core's enter/exit
// requests, routes rising edges through the channel masks to the other
// member cores and drives one stretched request channel per core and type.
module ct_had_xtrig_matrix
   import ct_had_xtrig_matrix_pkg::*;
#(
   parameter int unsigned CORE_NUM = 4,
   parameter int unsigned HOLD_CYC = XT_HOLD_CYC_DEF,
   parameter int unsigned TMO_CYC  = XT_TMO_CYC_DEF
) (
   input  logic                  forever_coreclk,
   input  logic                  cpurst_b,
   ct_had_xtrig_matrix_if.slave  core_if,
   input  logic [CORE_NUM-1:0]   xtrig_enter_mask,
   input  logic [CORE_NUM-1:0]   xtrig_exit_mask,
   input  logic                  xtrig_tmo_clr,
   output logic                  xtrig_busy,
   output logic [2*CORE_NUM-1:0] xtrig_tmo
);

   logic [CORE_NUM-1:0] enter_req_f_r;
   logic [CORE_NUM-1:0] enter_req_ff_r;
   logic [CORE_NUM-1:0] exit_req_f_r;
   logic [CORE_NUM-1:0] exit_req_ff_r;
   logic                cap_vld_f_r;
   logic                cap_vld_ff_r;
   logic [CORE_NUM-1:0] dbgon_meta_r;
   logic [CORE_NUM-1:0] dbgon_sync_r;

   logic [CORE_NUM-1:0] enter_edge_s;
   logic [CORE_NUM-1:0] exit_edge_s;
   logic [CORE_NUM-1:0] enter_tgt_s;
   logic [CORE_NUM-1:0] exit_tgt_s;
   logic [CORE_NUM-1:0] enter_sel_s;
   logic [CORE_NUM-1:0] exit_sel_s;
   logic [CORE_NUM-1:0] enter_req_s;
   logic [CORE_NUM-1:0] exit_req_s;
   logic [CORE_NUM-1:0] enter_busy_s;
   logic [CORE_NUM-1:0] exit_busy_s;

   // two-stage capture of the outgoing requests; cap_vld masks edges until req_ff holds real samples,
   // so a source already high when reset releases does not fire
   always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         enter_req_f_r  <= {CORE_NUM{1'b0}};
         enter_req_ff_r <= {CORE_NUM{1'b0}};
         exit_req_f_r   <= {CORE_NUM{1'b0}};
         exit_req_ff_r  <= {CORE_NUM{1'b0}};
         cap_vld_f_r    <= 1'b0;
         cap_vld_ff_r   <= 1'b0;
      end else begin
         enter_req_f_r  <= core_if.core_enter_req_o;
         enter_req_ff_r <= enter_req_f_r;
         exit_req_f_r   <= core_if.core_exit_req_o;
         exit_req_ff_r  <= exit_req_f_r;
         cap_vld_f_r    <= 1'b1;
         cap_vld_ff_r   <= cap_vld_f_r;
      end
   end

   // two-flop synchroniser for the asynchronous debug-mode status
   always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         dbgon_meta_r <= {CORE_NUM{1'b0}};
         dbgon_sync_r <= {CORE_NUM{1'b0}};
      end else begin
         dbgon_meta_r <= core_if.core_dbgon;
         dbgon_sync_r <= dbgon_meta_r;
      end
   end

   // rising-edge detection on the captured requests
   always_comb begin
      enter_edge_s = {CORE_NUM{1'b0}};
      exit_edge_s  = {CORE_NUM{1'b0}};
      if (cap_vld_ff_r) begin
         enter_edge_s = enter_req_f_r & ~enter_req_ff_r;
         exit_edge_s  = exit_req_f_r & ~exit_req_ff_r;
      end else begin
         enter_edge_s = {CORE_NUM{1'b0}};
         exit_edge_s  = {CORE_NUM{1'b0}};
      end
   end

   // mask routing, skipping sources and cores already in the requested state; enter wins per-core conflicts
   always_comb begin
      enter_tgt_s = {CORE_NUM{1'b0}};
      exit_tgt_s  = {CORE_NUM{1'b0}};
      if (|(enter_edge_s & xtrig_enter_mask)) begin
         enter_tgt_s = xtrig_enter_mask & ~enter_edge_s & ~dbgon_sync_r;
      end else begin
         enter_tgt_s = {CORE_NUM{1'b0}};
      end
      if (|(exit_edge_s & xtrig_exit_mask)) begin
         exit_tgt_s = xtrig_exit_mask & ~exit_edge_s & dbgon_sync_r;
      end else begin
         exit_tgt_s = {CORE_NUM{1'b0}};
      end
      enter_sel_s = enter_tgt_s & ~exit_busy_s;
      exit_sel_s  = exit_tgt_s & ~enter_tgt_s & ~enter_busy_s;
   end

   for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_core
      ct_had_xtrig_chan #(
         .HOLD_CYC (HOLD_CYC),
         .TMO_CYC  (TMO_CYC)
      ) u_enter_chan (
         .forever_coreclk (forever_coreclk),
         .cpurst_b        (cpurst_b),
         .trig            (enter_sel_s[gi]),
         .ack             (dbgon_sync_r[gi]),
         .tmo_clr         (xtrig_tmo_clr),
         .req             (enter_req_s[gi]),
         .busy            (enter_busy_s[gi]),
         .tmo             (xtrig_tmo[gi])
      );

      ct_had_xtrig_chan #(
         .HOLD_CYC (HOLD_CYC),
         .TMO_CYC  (TMO_CYC)
      ) u_exit_chan (
         .forever_coreclk (forever_coreclk),
         .cpurst_b        (cpurst_b),
         .trig            (exit_sel_s[gi]),
         .ack             (~dbgon_sync_r[gi]),
         .tmo_clr         (xtrig_tmo_clr),
         .req             (exit_req_s[gi]),
         .busy            (exit_busy_s[gi]),
         .tmo             (xtrig_tmo[CORE_NUM+gi])
      );
   end

   assign core_if.core_enter_req_i = enter_req_s;
   assign core_if.core_exit_req_i  = exit_req_s;
   assign xtrig_busy               = |{enter_busy_s, exit_busy_s};

endmodule

// File: tb/tb_ct_had_xtrig_matrix.sv
// Testbench for ct_had_xtrig_matrix: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a timeline-based model.
module tb_ct_had_xtrig_matrix;

   localparam int NC   = 8000;
   localparam int HOLD = 8;
   localparam int TMO  = 255;

   logic       forever_coreclk = 1'b0;
   logic       cpurst_b;
   logic [3:0] xtrig_enter_mask;
   logic [3:0] xtrig_exit_mask;
   logic       xtrig_tmo_clr;
   logic       xtrig_busy;
   logic [7:0] xtrig_tmo;

   ct_had_xtrig_matrix_if #(.CORE_NUM(4)) xif();

   ct_had_xtrig_matrix #(.CORE_NUM(4), .HOLD_CYC(HOLD), .TMO_CYC(TMO)) u_dut (
      .forever_coreclk  (forever_coreclk),
      .cpurst_b         (cpurst_b),
      .core_if          (xif),
      .xtrig_enter_mask (xtrig_enter_mask),
      .xtrig_exit_mask  (xtrig_exit_mask),
      .xtrig_tmo_clr    (xtrig_tmo_clr),
      .xtrig_busy       (xtrig_busy),
      .xtrig_tmo        (xtrig_tmo)
   );

   always #5 forever_coreclk = ~forever_coreclk;

   // stimulus values applied in the next interval
   bit [3:0] r_en, r_ex, r_db, r_enm, r_exm;
   bit       r_clr;

   // input history per interval (interval q = time after posedge q)
   bit [3:0] h_en [NC];
   bit [3:0] h_ex [NC];
   bit [3:0] h_db [NC];
   bit [3:0] h_enm[NC];
   bit [3:0] h_exm[NC];
   bit       h_clr[NC];

   // model: channel ch<4 is enter for core ch, ch>=4 is exit for core ch-4
   bit [7:0] m_act, m_ackh, m_tmo;
   int       m_start[8];
   int       q  = 4;
   int       p1 = 0;

   int n_chk = 0;
   int n_err = 0;
   int hi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (interval %0d)", tag, obs, exp, q);
      end
   endtask

   // advance the model over the interval that this posedge closes
   task automatic model_step();
      bit [3:0] e_en, e_ex, dbs, t_en, t_ex, s_en, s_ex;
      bit [7:0] act0;
      int       cur, age, ci;
      bit       trig, ack, set;
      q++;
      if (cpurst_b) begin
         cur  = q - 1;
         e_en = 4'b0; e_ex = 4'b0; dbs = 4'b0;
         if (cur >= p1 + 1) begin
            e_en = h_en[cur-1] & ~h_en[cur-2];
            e_ex = h_ex[cur-1] & ~h_ex[cur-2];
            dbs  = h_db[cur-2];
         end
         t_en = ((e_en & h_enm[cur]) != 4'b0) ? (h_enm[cur] & ~e_en & ~dbs) : 4'b0;
         t_ex = ((e_ex & h_exm[cur]) != 4'b0) ? (h_exm[cur] & ~e_ex & dbs) : 4'b0;
         act0 = m_act;
         s_en = t_en & ~act0[7:4];
         s_ex = t_ex & ~t_en & ~act0[3:0];
         for (int ch = 0; ch < 8; ch++) begin
            ci   = ch % 4;
            trig = (ch < 4) ? s_en[ci] : s_ex[ci];
            ack  = (ch < 4) ? dbs[ci] : ~dbs[ci];
            set  = 1'b0;
            if (m_act[ch]) begin
               age = cur - m_start[ch];
               if (age < HOLD && ack) m_ackh[ch] = 1'b1;
               if (age == HOLD - 1) begin
                  if (m_ackh[ch]) m_act[ch] = 1'b0;
               end else if (age >= HOLD) begin
                  if (ack) m_act[ch] = 1'b0;
                  else if (age == HOLD + TMO) begin
                     m_act[ch] = 1'b0;
                     set = 1'b1;
                  end
               end
            end else if (trig) begin
               m_act[ch]   = 1'b1;
               m_start[ch] = cur + 1;
               m_ackh[ch]  = 1'b0;
            end
            if (set) m_tmo[ch] = 1'b1;
            else if (h_clr[cur]) m_tmo[ch] = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      chk("enter_req_i", 32'(xif.core_enter_req_i), 32'(m_act[3:0]));
      chk("exit_req_i",  32'(xif.core_exit_req_i),  32'(m_act[7:4]));
      chk("busy",        32'(xtrig_busy),           32'(|m_act));
      chk("tmo",         32'(xtrig_tmo),            32'(m_tmo));
   endtask

   // one clock: model update, drive inputs (+ optional reset action), sample at negedge
   task automatic tick(input int rst_act);
      @(posedge forever_coreclk);
      model_step();
      #1;
      xif.core_enter_req_o = r_en;
      xif.core_exit_req_o  = r_ex;
      xif.core_dbgon       = r_db;
      xtrig_enter_mask     = r_enm;
      xtrig_exit_mask      = r_exm;
      xtrig_tmo_clr        = r_clr;
      h_en[q] = r_en; h_ex[q] = r_ex; h_db[q] = r_db;
      h_enm[q] = r_enm; h_exm[q] = r_exm; h_clr[q] = r_clr;
      if (rst_act == 1) begin
         cpurst_b = 1'b0;
         m_act = 8'b0; m_ackh = 8'b0; m_tmo = 8'b0;
         #1;
         chk("rst_enter_req_i", 32'(xif.core_enter_req_i), 32'd0);
         chk("rst_exit_req_i",  32'(xif.core_exit_req_i),  32'd0);
         chk("rst_busy",        32'(xtrig_busy),           32'd0);
      end else if (rst_act == 2) begin
         cpurst_b = 1'b1;
         p1 = q + 1;
      end
      @(negedge forever_coreclk);
      compare_all();
   endtask

   initial begin
      int bi;
      cpurst_b = 1'b0;
      r_en = 4'b0; r_ex = 4'b0; r_db = 4'b0; r_enm = 4'b0; r_exm = 4'b0; r_clr = 1'b0;
      xif.core_enter_req_o = 4'b0; xif.core_exit_req_o = 4'b0; xif.core_dbgon = 4'b0;
      xtrig_enter_mask = 4'b0; xtrig_exit_mask = 4'b0; xtrig_tmo_clr = 1'b0;
      repeat (3) tick(0);
      tick(2);

      // route enter from core0 to cores 1-3, which confirm 5 cycles after the source rise
      r_enm = 4'b1111;
      repeat (6) tick(0);
      r_en = 4'b0001;
      tick(0);
      tick(0);
      hi = 0;
      for (int k = 2; k < 20; k++) begin
         if (k == 5) r_db = 4'b1110;
         tick(0);
         if (k == 2) chk("route_first_cycle", 32'(xif.core_enter_req_i), 32'h0000_000e);
         if (xif.core_enter_req_i[1]) hi++;
      end
      chk("route_pulse_len", 32'(hi), 32'd8);
      r_en = 4'b0000;
      repeat (4) tick(0);

      // exit from core0 to core1, which never leaves debug: full timeout
      r_exm = 4'b0011;
      repeat (3) tick(0);
      r_ex = 4'b0001;
      tick(0);
      tick(0);
      hi = 0;
      for (int k = 2; k < 300; k++) begin
         tick(0);
         if (xif.core_exit_req_i[1]) hi++;
      end
      chk("tmo_pulse_len", 32'(hi), 32'd264);
      chk("tmo_flag_set", 32'(xtrig_tmo), 32'h0000_0020);
      r_clr = 1'b1; tick(0);
      r_clr = 1'b0; tick(0);
      chk("tmo_flag_clr", 32'(xtrig_tmo), 32'd0);

      // second timeout with the clear pulse landing on the same cycle as the set
      r_ex = 4'b0000;
      repeat (3) tick(0);
      r_ex = 4'b0001;
      tick(0);
      tick(0);
      for (int k = 2; k < 270; k++) begin
         r_clr = (k == 265);
         tick(0);
      end
      r_clr = 1'b0;
      chk("tmo_set_beats_clr", 32'(xtrig_tmo), 32'h0000_0020);
      r_clr = 1'b1; tick(0);
      r_clr = 1'b0; tick(0);
      r_ex = 4'b0000;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            bi = int'($urandom_range(0, 3));
            r_en[bi] = ~r_en[bi];
         end
         if ($urandom_range(0, 7) == 0) begin
            bi = int'($urandom_range(0, 3));
            r_ex[bi] = ~r_ex[bi];
         end
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 19) == 0) r_db[b] = ~r_db[b];
         end
         if ($urandom_range(0, 149) == 0) r_enm = 4'($urandom);
         if ($urandom_range(0, 149) == 0) r_exm = 4'($urandom);
         r_clr = ($urandom_range(0, 59) == 0);
         tick(0);
      end

      // settle, then reset while channels sit in WAIT_ACK with a source held high
      r_en = 4'b0; r_ex = 4'b0; r_db = 4'b0; r_clr = 1'b0;
      repeat (300) tick(0);
      r_enm = 4'b1111;
      r_en  = 4'b1000;
      repeat (13) tick(0);
      chk("pre_rst_wait_ack", 32'(xif.core_enter_req_i), 32'h0000_0007);
      tick(1);
      repeat (3) tick(0);
      tick(2);
      hi = 0;
      for (int k = 0; k < 30; k++) begin
         tick(0);
         if (xif.core_enter_req_i != 4'b0) hi++;
      end
      chk("no_retrigger_after_rst", 32'(hi), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ct_had_xtrig_matrix.md
# ct_had_xtrig_matrix

Cluster-level debug cross-trigger matrix that sits directly upstream of each core's HAD event block. It collects every core's outgoing enter/exit-debug request, routes it through programmable channel masks to the other member cores, and drives each target's incoming request line. Each target line is held as a stretched level until the target's debug state confirms it, or until a timeout expires. It runs on the ungated core clock so routing continues while target cores are clock-gated.

## Interface
- CORE_NUM, 4: number of cores in the cluster.
- HOLD_CYC, 8: minimum assertion length of a target request, in clocks (≥2).
- TMO_CYC, 255: cycles spent in WAIT_ACK before giving up (8-bit counter).
- forever_coreclk  in  1  clock, never gated.
- cpurst_b  in  1  reset: asynchronous, active-low. Clock is forever_coreclk.
- core_enter_req_o  in  CORE_NUM  per-core outgoing enter request; level; synchronous to a gated derivative of forever_coreclk.
- core_exit_req_o  in  CORE_NUM  per-core outgoing exit request; same properties as core_enter_req_o.
- core_dbgon  in  CORE_NUM  per-core debug-mode status; asynchronous.
- xtrig_enter_mask  in  CORE_NUM  enter-channel membership, quasi-static.
- xtrig_exit_mask  in  CORE_NUM  exit-channel membership, quasi-static.
- xtrig_tmo_clr  in  1  single-cycle pulse; clears all timeout flags.
- core_enter_req_i  out  CORE_NUM  per-core incoming enter request, registered.
- core_exit_req_i  out  CORE_NUM  per-core incoming exit request, registered.
- xtrig_busy  out  1  OR of all channels not in IDLE.
- xtrig_tmo  out  2*CORE_NUM  sticky timeout flags. Bits [CORE_NUM-1:0] are enter channels; the upper bits are exit channels.

## Operation
- Input capture: core_*_req_o is registered once into req_f, then into req_ff. Source edge = req_f & ~req_ff.
- core_dbgon passes through a 2-flop synchroniser to produce dbgon_s.
- Enter routing: enter_hit = |(edge_enter & xtrig_enter_mask). When enter_hit is set, target set = xtrig_enter_mask & ~edge_enter & ~dbgon_s.
  - Sources never retrigger themselves.
  - Cores already in debug are skipped.
  - Multiple same-cycle sources merge (OR).
- Exit routing: same rule using xtrig_exit_mask, with dbgon_s replacing ~dbgon_s.
- Each of the 2*CORE_NUM channels has its own FSM: IDLE → ASSERT → WAIT_ACK → IDLE.
  - IDLE: on target select, go to ASSERT and load hold_cnt = HOLD_CYC-1.
  - ASSERT: output = 1; hold_cnt decrements. At 0, go to IDLE if ack_seen, else go to WAIT_ACK with tmo_cnt = 0.
  - WAIT_ACK: output = 1. On ack, go to IDLE. On tmo_cnt == TMO_CYC, set the xtrig_tmo bit and go to IDLE.
  - Enter ack: dbgon_s = 1. Exit ack: dbgon_s = 0.
  - ack_seen latches during ASSERT and clears on entry to ASSERT.
- A trigger to a channel not in IDLE is ignored. There is no queueing and no restart of the counters.
- Per-core conflict: if enter and exit select the same core in the same cycle, enter wins and the exit select is dropped. An exit select while that core's enter channel is busy is also dropped, and vice versa.
- Mask changes affect only new triggers. Channels already in flight complete normally.
- xtrig_tmo_clr clears the flags. A timeout set in the same cycle as the clear wins (flag ends up 1).

## Timing
- Reset values: all outputs are 0, all FSMs are IDLE, all counters are 0, and the synchronisers are 0.
- Latency: source request rises at clock edge N, req_f is set at N+1, and target output is 1 at N+2.
- Minimum output pulse is HOLD_CYC cycles. Maximum is HOLD_CYC + TMO_CYC + 1 cycles.
- Output deasserts the cycle after the exit condition is evaluated.
- Ack-to-deassert latency: 1 cycle after dbgon_s, which is 3 cycles after raw core_dbgon.
- A source request held high produces exactly one trigger. A new trigger requires the source to drop and rise again.
- Asynchronous reset mid-pulse drops every output to 0 immediately.

## Structure
- Shared package holds:
  - channel FSM state encoding: IDLE=2'b00, ASSERT=2'b01, WAIT_ACK=2'b10
  - default HOLD_CYC and TMO_CYC values
  - counter width constant (8)
- One sub-module, ct_had_xtrig_chan: a single channel containing the FSM, hold/timeout counters, ack_seen and the sticky flag.
  - Inputs: trig, ack, tmo_clr.
  - Outputs: req, busy, tmo.
  - Instanced 2*CORE_NUM times.
- The top level contains capture, synchronisers, routing and conflict arbitration.

## Test plan
- Route enter: enter_mask=4'b1111; core0 raises enter_req_o; cores 1–3 raise dbgon 5 cycles later.
  - core_enter_req_i = 4'b1110 from N+2.
  - Outputs are held for 8 cycles, then drop 1 cycle after the hold ends.
  - xtrig_tmo = 0.
- Skip and self-exclusion: enter_mask=4'b0111 with core1 already in debug; core2 triggers.
  - Only core0's output pulses.
  - Core3 is not in the mask, so it stays at 0.
- Timeout: core0 triggers exit to core1, which never drops dbgon.
  - core_exit_req_i[1] stays high for 8+255+1 cycles.
  - xtrig_tmo[CORE_NUM+1] is set, then cleared by xtrig_tmo_clr.
- Conflict: core0 enter and core3 exit both target core1 in the same cycle.
  - Enter is asserted; core_exit_req_i[1] stays 0.
  - Retrigger during ASSERT is ignored, so the pulse length is unchanged.
- Reset mid-operation: assert cpurst_b=0 during WAIT_ACK.
  - All outputs are 0 the same cycle.
  - After release, a held-high source does not retrigger.
